// File: rtl/aq_vpu_fp_dis_buf_if.sv
// FP dispatch bundle: VIDU dispatch packet, FP forward bus and EX1 issue port.
// The buffer uses the slave modport; the surrounding pipeline uses master.
interface aq_vpu_fp_dis_buf_if;
   logic        vidu_vpu_vid_fp_inst_vld;
   logic        vpu_vidu_fp_dis_rdy;
   logic [19:0] vidu_vpu_vid_fp_inst_func;
   logic [9:0]  vidu_vpu_vid_fp_inst_eu;
   logic [4:0]  vidu_vpu_vid_fp_inst_dstf_reg;
   logic        vidu_vpu_vid_fp_inst_dstf_vld;
   logic [63:0] vidu_vpu_vid_fp_inst_srcf0_data;
   logic [63:0] vidu_vpu_vid_fp_inst_srcf1_data;
   logic [63:0] vidu_vpu_vid_fp_inst_srcf2_data;
   logic [4:0]  vidu_vpu_vid_fp_inst_srcf2_reg;
   logic        vidu_vpu_vid_fp_inst_srcf2_vld;
   logic        vidu_vpu_vid_fp_inst_srcf2_rdy;

   logic        vpu_fp_fwd_vld;
   logic [4:0]  vpu_fp_fwd_reg;
   logic [63:0] vpu_fp_fwd_data;

   logic        fp_ex1_issue_vld;
   logic        fp_ex1_issue_rdy;
   logic [19:0] fp_ex1_func;
   logic [9:0]  fp_ex1_eu;
   logic [4:0]  fp_ex1_dstf_reg;
   logic        fp_ex1_dstf_vld;
   logic [63:0] fp_ex1_srcf0_data;
   logic [63:0] fp_ex1_srcf1_data;
   logic [63:0] fp_ex1_srcf2_data;
   logic        fp_dis_buf_empty;

   modport slave (
      input  vidu_vpu_vid_fp_inst_vld, vidu_vpu_vid_fp_inst_func, vidu_vpu_vid_fp_inst_eu,
             vidu_vpu_vid_fp_inst_dstf_reg, vidu_vpu_vid_fp_inst_dstf_vld,
             vidu_vpu_vid_fp_inst_srcf0_data, vidu_vpu_vid_fp_inst_srcf1_data,
             vidu_vpu_vid_fp_inst_srcf2_data, vidu_vpu_vid_fp_inst_srcf2_reg,
             vidu_vpu_vid_fp_inst_srcf2_vld, vidu_vpu_vid_fp_inst_srcf2_rdy,
             vpu_fp_fwd_vld, vpu_fp_fwd_reg, vpu_fp_fwd_data, fp_ex1_issue_rdy,
      output vpu_vidu_fp_dis_rdy, fp_ex1_issue_vld, fp_ex1_func, fp_ex1_eu,
             fp_ex1_dstf_reg, fp_ex1_dstf_vld, fp_ex1_srcf0_data, fp_ex1_srcf1_data,
             fp_ex1_srcf2_data, fp_dis_buf_empty
   );

   modport master (
      output vidu_vpu_vid_fp_inst_vld, vidu_vpu_vid_fp_inst_func, vidu_vpu_vid_fp_inst_eu,
             vidu_vpu_vid_fp_inst_dstf_reg, vidu_vpu_vid_fp_inst_dstf_vld,
             vidu_vpu_vid_fp_inst_srcf0_data, vidu_vpu_vid_fp_inst_srcf1_data,
             vidu_vpu_vid_fp_inst_srcf2_data, vidu_vpu_vid_fp_inst_srcf2_reg,
             vidu_vpu_vid_fp_inst_srcf2_vld, vidu_vpu_vid_fp_inst_srcf2_rdy,
             vpu_fp_fwd_vld, vpu_fp_fwd_reg, vpu_fp_fwd_data, fp_ex1_issue_rdy,
      input  vpu_vidu_fp_dis_rdy, fp_ex1_issue_vld, fp_ex1_func, fp_ex1_eu,
             fp_ex1_dstf_reg, fp_ex1_dstf_vld, fp_ex1_srcf0_data, fp_ex1_srcf1_data,
             fp_ex1_srcf2_data, fp_dis_buf_empty
   );
endinterface

// File: rtl/aq_vpu_fp_dis_buf.sv
// Two-entry in-order FP dispatch buffer: holds packets until srcf2 is final
// (capturing forwarded data), then issues them to EX1 under valid/ready.
module aq_vpu_fp_dis_buf (
   input  logic                   cpuclk,
   input  logic                   cpurst_b,
   input  logic                   rtu_yy_xx_flush,
   aq_vpu_fp_dis_buf_if.slave     bus
);
   localparam int ENTRY_NUM = 2;

   typedef struct packed {
      logic        vld;
      logic        f2_wait;
      logic [19:0] func;
      logic [9:0]  eu;
      logic [4:0]  dstf_reg;
      logic        dstf_vld;
      logic [63:0] srcf0;
      logic [63:0] srcf1;
      logic [63:0] srcf2;
      logic [4:0]  srcf2_reg;
   } entry_t;

   entry_t     ent [ENTRY_NUM];
   entry_t     head;
   entry_t     new_ent;
   logic       wr_ptr;
   logic       rd_ptr;
   logic [1:0] count;
   logic       enq;
   logic       deq;
   logic       f2_pend;
   logic       fwd_hit_in;

   // Ready looks only at the registered count, keeping EX1 ready off the VIDU path.
   assign bus.vpu_vidu_fp_dis_rdy = (count != 2'(ENTRY_NUM));
   assign enq        = bus.vidu_vpu_vid_fp_inst_vld & bus.vpu_vidu_fp_dis_rdy;
   assign head       = ent[rd_ptr];
   assign deq        = bus.fp_ex1_issue_vld & bus.fp_ex1_issue_rdy;
   assign f2_pend    = bus.vidu_vpu_vid_fp_inst_srcf2_vld & ~bus.vidu_vpu_vid_fp_inst_srcf2_rdy;
   assign fwd_hit_in = f2_pend & bus.vpu_fp_fwd_vld &
                       (bus.vpu_fp_fwd_reg == bus.vidu_vpu_vid_fp_inst_srcf2_reg);

   always_comb begin
      new_ent           = '0;
      new_ent.vld       = 1'b1;
      new_ent.f2_wait   = f2_pend & ~fwd_hit_in;
      new_ent.func      = bus.vidu_vpu_vid_fp_inst_func;
      new_ent.eu        = bus.vidu_vpu_vid_fp_inst_eu;
      new_ent.dstf_reg  = bus.vidu_vpu_vid_fp_inst_dstf_reg;
      new_ent.dstf_vld  = bus.vidu_vpu_vid_fp_inst_dstf_vld;
      new_ent.srcf0     = bus.vidu_vpu_vid_fp_inst_srcf0_data;
      new_ent.srcf1     = bus.vidu_vpu_vid_fp_inst_srcf1_data;
      new_ent.srcf2     = fwd_hit_in ? bus.vpu_fp_fwd_data : bus.vidu_vpu_vid_fp_inst_srcf2_data;
      new_ent.srcf2_reg = bus.vidu_vpu_vid_fp_inst_srcf2_reg;
   end

   // NOTE: payload is reset too, so the EX1 fields read a defined all-zero entry
   // after reset rather than X; state updates use non-blocking assignments.
   always_ff @(posedge cpuclk or negedge cpurst_b) begin
      if (!cpurst_b) begin
         for (int i = 0; i < ENTRY_NUM; i++) ent[i] <= '0;
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         count  <= 2'd0;
      end else if (rtu_yy_xx_flush) begin
         for (int i = 0; i < ENTRY_NUM; i++) ent[i].vld <= 1'b0;
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         count  <= 2'd0;
      end else begin
         for (int i = 0; i < ENTRY_NUM; i++) begin
            if (ent[i].vld && ent[i].f2_wait && bus.vpu_fp_fwd_vld &&
                (bus.vpu_fp_fwd_reg == ent[i].srcf2_reg)) begin
               ent[i].srcf2   <= bus.vpu_fp_fwd_data;
               ent[i].f2_wait <= 1'b0;
            end
         end
         if (deq) begin
            ent[rd_ptr].vld <= 1'b0;
            rd_ptr          <= ~rd_ptr;
         end
         // The write slot is never the resident entry, so this cannot clash with capture.
         if (enq) begin
            ent[wr_ptr] <= new_ent;
            wr_ptr      <= ~wr_ptr;
         end
         if (enq && !deq)      count <= count + 2'd1;
         else if (deq && !enq) count <= count - 2'd1;
      end
   end

   assign bus.fp_ex1_issue_vld  = head.vld & ~head.f2_wait;
   assign bus.fp_ex1_func       = head.func;
   assign bus.fp_ex1_eu         = head.eu;
   assign bus.fp_ex1_dstf_reg   = head.dstf_reg;
   assign bus.fp_ex1_dstf_vld   = head.dstf_vld;
   assign bus.fp_ex1_srcf0_data = head.srcf0;
   assign bus.fp_ex1_srcf1_data = head.srcf1;
   assign bus.fp_ex1_srcf2_data = head.srcf2;
   assign bus.fp_dis_buf_empty  = (count == 2'd0);
endmodule

// File: tb/tb_aq_vpu_fp_dis_buf.sv
// Directed bench for aq_vpu_fp_dis_buf: stimulus pushes expected packets into a
// scoreboard queue; a negedge monitor pops and compares every EX1 handshake.
module tb_aq_vpu_fp_dis_buf;
   logic cpuclk   = 1'b0;
   logic cpurst_b = 1'b0;
   logic rtu_yy_xx_flush = 1'b0;

   aq_vpu_fp_dis_buf_if bus ();

   aq_vpu_fp_dis_buf dut (
      .cpuclk          (cpuclk),
      .cpurst_b        (cpurst_b),
      .rtu_yy_xx_flush (rtu_yy_xx_flush),
      .bus             (bus.slave)
   );

   always #5 cpuclk = ~cpuclk;

   typedef struct {
      logic [19:0] func;
      logic [9:0]  eu;
      logic [4:0]  dstf_reg;
      logic        dstf_vld;
      logic [63:0] f0;
      logic [63:0] f1;
      logic [63:0] f2;
   } pkt_t;

   pkt_t sb[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge cpuclk);
      #1;
   endtask

   // Drives one dispatch packet; non-srcf2 payload fields are fixed functions of func.
   task automatic drive_pkt(input logic [19:0] func, input logic [63:0] f2,
                            input logic f2_vld, input logic f2_rdy, input logic [4:0] f2_reg);
      bus.vidu_vpu_vid_fp_inst_vld        = 1'b1;
      bus.vidu_vpu_vid_fp_inst_func       = func;
      bus.vidu_vpu_vid_fp_inst_eu         = func[9:0];
      bus.vidu_vpu_vid_fp_inst_dstf_reg   = func[4:0];
      bus.vidu_vpu_vid_fp_inst_dstf_vld   = func[0];
      bus.vidu_vpu_vid_fp_inst_srcf0_data = {32'hA0A0_0000, 12'h0, func};
      bus.vidu_vpu_vid_fp_inst_srcf1_data = {32'hB1B1_0000, 12'h0, func};
      bus.vidu_vpu_vid_fp_inst_srcf2_data = f2;
      bus.vidu_vpu_vid_fp_inst_srcf2_vld  = f2_vld;
      bus.vidu_vpu_vid_fp_inst_srcf2_rdy  = f2_rdy;
      bus.vidu_vpu_vid_fp_inst_srcf2_reg  = f2_reg;
   endtask

   task automatic expect_pkt(input logic [19:0] func, input logic [63:0] f2);
      pkt_t p;
      p.func     = func;
      p.eu       = func[9:0];
      p.dstf_reg = func[4:0];
      p.dstf_vld = func[0];
      p.f0       = {32'hA0A0_0000, 12'h0, func};
      p.f1       = {32'hB1B1_0000, 12'h0, func};
      p.f2       = f2;
      sb.push_back(p);
   endtask

   task automatic idle_in();
      bus.vidu_vpu_vid_fp_inst_vld = 1'b0;
      bus.vpu_fp_fwd_vld           = 1'b0;
   endtask

   task automatic fwd(input logic [4:0] r, input logic [63:0] d);
      bus.vpu_fp_fwd_vld  = 1'b1;
      bus.vpu_fp_fwd_reg  = r;
      bus.vpu_fp_fwd_data = d;
   endtask

   // Monitor: every accepted issue must match the oldest expected packet.
   always @(negedge cpuclk) begin
      if (cpurst_b && bus.fp_ex1_issue_vld && bus.fp_ex1_issue_rdy) begin
         if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_issue: got func 0x%0h, expected no packet at %0t",
                     bus.fp_ex1_func, $time);
         end else begin
            pkt_t p;
            p = sb.pop_front();
            check("issue_func",  64'(bus.fp_ex1_func),     64'(p.func));
            check("issue_eu",    64'(bus.fp_ex1_eu),       64'(p.eu));
            check("issue_dreg",  64'(bus.fp_ex1_dstf_reg), 64'(p.dstf_reg));
            check("issue_dvld",  64'(bus.fp_ex1_dstf_vld), 64'(p.dstf_vld));
            check("issue_f0",    bus.fp_ex1_srcf0_data,    p.f0);
            check("issue_f1",    bus.fp_ex1_srcf1_data,    p.f1);
            check("issue_f2",    bus.fp_ex1_srcf2_data,    p.f2);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      drive_pkt(20'h0, 64'h0, 1'b0, 1'b1, 5'd0);
      idle_in();
      bus.vpu_fp_fwd_reg   = 5'd0;
      bus.vpu_fp_fwd_data  = 64'h0;
      bus.fp_ex1_issue_rdy = 1'b1;

      // Reset state
      #12;
      check("rst_dis_rdy",   64'(bus.vpu_vidu_fp_dis_rdy), 64'd1);
      check("rst_issue_vld", 64'(bus.fp_ex1_issue_vld),    64'd0);
      check("rst_empty",     64'(bus.fp_dis_buf_empty),    64'd1);
      check("rst_func",      64'(bus.fp_ex1_func),         64'd0);
      check("rst_f2",        bus.fp_ex1_srcf2_data,        64'd0);
      cpurst_b = 1'b1;
      step();

      // 1: single packet, one-cycle latency
      drive_pkt(20'h00123, 64'h0000_0000_0000_1230, 1'b0, 1'b1, 5'd1);
      expect_pkt(20'h00123, 64'h0000_0000_0000_1230);
      step();
      idle_in();
      check("t1_issue_vld", 64'(bus.fp_ex1_issue_vld), 64'd1);
      check("t1_empty",     64'(bus.fp_dis_buf_empty), 64'd0);
      step();
      check("t1_empty_after", 64'(bus.fp_dis_buf_empty), 64'd1);
      check("t1_issue_after", 64'(bus.fp_ex1_issue_vld), 64'd0);

      // 2: fill while EX1 stalled, third dispatch refused, in-order drain
      bus.fp_ex1_issue_rdy = 1'b0;
      drive_pkt(20'h0B0B0, 64'h0000_0000_0000_B0B0, 1'b0, 1'b1, 5'd2);
      expect_pkt(20'h0B0B0, 64'h0000_0000_0000_B0B0);
      step();
      check("t2_rdy_cnt1", 64'(bus.vpu_vidu_fp_dis_rdy), 64'd1);
      drive_pkt(20'h0C0C1, 64'h0000_0000_0000_C0C1, 1'b0, 1'b1, 5'd2);
      expect_pkt(20'h0C0C1, 64'h0000_0000_0000_C0C1);
      step();
      check("t2_rdy_full", 64'(bus.vpu_vidu_fp_dis_rdy), 64'd0);
      drive_pkt(20'h0D0D0, 64'h0000_0000_0000_D0D0, 1'b0, 1'b1, 5'd2);
      step();
      idle_in();
      check("t2_rdy_still_full", 64'(bus.vpu_vidu_fp_dis_rdy), 64'd0);
      check("t2_head_vld",       64'(bus.fp_ex1_issue_vld),    64'd1);
      bus.fp_ex1_issue_rdy = 1'b1;
      step();
      check("t2_rdy_reassert", 64'(bus.vpu_vidu_fp_dis_rdy), 64'd1);
      step();
      check("t2_empty", 64'(bus.fp_dis_buf_empty), 64'd1);

      // 3: wait on srcf2 reg 7; a reg-6 forward must not release it
      drive_pkt(20'h0E0E0, 64'h0000_0000_0000_1111, 1'b1, 1'b0, 5'd7);
      expect_pkt(20'h0E0E0, 64'h0000_0000_DEAD_BEEF);
      step();
      idle_in();
      check("t3_wait", 64'(bus.fp_ex1_issue_vld), 64'd0);
      fwd(5'd6, 64'h0000_0000_0000_0BAD);
      step();
      check("t3_wrong_reg", 64'(bus.fp_ex1_issue_vld), 64'd0);
      fwd(5'd7, 64'h0000_0000_DEAD_BEEF);
      step();
      idle_in();
      check("t3_released", 64'(bus.fp_ex1_issue_vld), 64'd1);
      step();
      check("t3_empty", 64'(bus.fp_dis_buf_empty), 64'd1);

      // 4: same-cycle forward hit on enqueue
      drive_pkt(20'h0F0F1, 64'h0000_0000_0000_2222, 1'b1, 1'b0, 5'd3);
      fwd(5'd3, 64'h0000_0000_3333_CAFE);
      expect_pkt(20'h0F0F1, 64'h0000_0000_3333_CAFE);
      step();
      idle_in();
      check("t4_issue_vld", 64'(bus.fp_ex1_issue_vld), 64'd1);
      step();
      check("t4_empty", 64'(bus.fp_dis_buf_empty), 64'd1);

      // 5: waiting head blocks a ready second entry, then back-to-back issue
      drive_pkt(20'h01010, 64'h0000_0000_0000_4444, 1'b1, 1'b0, 5'd9);
      expect_pkt(20'h01010, 64'h0000_0000_0000_9999);
      step();
      drive_pkt(20'h02021, 64'h0000_0000_0000_5555, 1'b1, 1'b1, 5'd9);
      expect_pkt(20'h02021, 64'h0000_0000_0000_5555);
      check("t5_blk0", 64'(bus.fp_ex1_issue_vld), 64'd0);
      step();
      idle_in();
      check("t5_blk1",  64'(bus.fp_ex1_issue_vld),    64'd0);
      check("t5_full",  64'(bus.vpu_vidu_fp_dis_rdy), 64'd0);
      step();
      check("t5_blk2", 64'(bus.fp_ex1_issue_vld), 64'd0);
      fwd(5'd9, 64'h0000_0000_0000_9999);
      step();
      idle_in();
      check("t5_head_go", 64'(bus.fp_ex1_issue_vld), 64'd1);
      step();
      check("t5_second_go", 64'(bus.fp_ex1_issue_vld), 64'd1);
      step();
      check("t5_empty", 64'(bus.fp_dis_buf_empty), 64'd1);

      // 6: flush with enqueue attempt and dequeue at count 2
      bus.fp_ex1_issue_rdy = 1'b0;
      drive_pkt(20'h03030, 64'h0000_0000_0000_3030, 1'b0, 1'b1, 5'd0);
      expect_pkt(20'h03030, 64'h0000_0000_0000_3030);
      step();
      drive_pkt(20'h04041, 64'h0000_0000_0000_4041, 1'b0, 1'b1, 5'd0);
      expect_pkt(20'h04041, 64'h0000_0000_0000_4041);
      step();
      check("t6_full", 64'(bus.vpu_vidu_fp_dis_rdy), 64'd0);
      rtu_yy_xx_flush = 1'b1;
      bus.fp_ex1_issue_rdy = 1'b1;
      drive_pkt(20'h05050, 64'h0000_0000_0000_5050, 1'b0, 1'b1, 5'd0);
      step();
      rtu_yy_xx_flush = 1'b0;
      idle_in();
      sb.delete();
      check("t6_empty",     64'(bus.fp_dis_buf_empty),    64'd1);
      check("t6_dis_rdy",   64'(bus.vpu_vidu_fp_dis_rdy), 64'd1);
      check("t6_issue_vld", 64'(bus.fp_ex1_issue_vld),    64'd0);

      // 7: flush drops a same-cycle enqueue at count 1
      bus.fp_ex1_issue_rdy = 1'b0;
      drive_pkt(20'h06060, 64'h0000_0000_0000_6060, 1'b0, 1'b1, 5'd0);
      step();
      rtu_yy_xx_flush = 1'b1;
      drive_pkt(20'h07071, 64'h0000_0000_0000_7071, 1'b0, 1'b1, 5'd0);
      step();
      rtu_yy_xx_flush = 1'b0;
      idle_in();
      check("t7_empty",     64'(bus.fp_dis_buf_empty), 64'd1);
      check("t7_issue_vld", 64'(bus.fp_ex1_issue_vld), 64'd0);
      bus.fp_ex1_issue_rdy = 1'b1;
      step();
      step();
      check("sb_drained", 64'(sb.size()), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
